// File: rtl/l2_mem_write_buffer_pkg.sv
// Block-interface constants and write-buffer FSM encoding shared by the L2 cache,
// the write buffer and the memory model.
package l2_mem_write_buffer_pkg;

    localparam int BLK_ADDR_W = 28;   // block address = byte address [31:4]
    localparam int BLK_DATA_W = 128;  // one cache block
    localparam int WB_DEPTH   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FETCH = 2'd2
    } wb_state_t;

endpackage

// File: rtl/l2_mem_write_buffer_wb_fifo_cam.sv
// Circular store of posted block writes with head/tail/count and a parallel
// address match that reports the youngest matching valid entry.
module wb_fifo_cam
    import l2_mem_write_buffer_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int ADDR_W = BLK_ADDR_W,
    parameter int DATA_W = BLK_DATA_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              ow_en,
    input  logic [PTR_W-1:0]  ow_idx,
    input  logic [DATA_W-1:0] ow_data,
    input  logic [ADDR_W-1:0] match_addr,
    input  logic              skip_head,
    output logic              hit,
    output logic [PTR_W-1:0]  hit_idx,
    output logic [DATA_W-1:0] hit_data,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    output logic              full
);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  cnt;
    logic [PTR_W-1:0]  scan_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage carries no reset; validity comes solely from head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= push_addr;
            data_mem[tail] <= push_data;
        end
        if (ow_en) begin
            data_mem[ow_idx] <= ow_data;
        end
    end

    // Scan oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head + PTR_W'(k);
            if ((CNT_W'(k) < cnt) && (addr_mem[scan_idx] == match_addr) &&
                !(skip_head && (k == 0))) begin
                hit     = 1'b1;
                hit_idx = scan_idx;
            end
        end
    end

    assign hit_data  = data_mem[hit_idx];
    assign head_addr = addr_mem[head];
    assign head_data = data_mem[head];
    assign count     = cnt;
    assign full      = (cnt == CNT_W'(DEPTH));

endmodule

// File: rtl/l2_mem_write_buffer.sv
// Posted write-back buffer between an L2 cache and slow memory: acks writes,
// drains them when idle, forwards read hits and fetches read misses.
// Optional build macro WB_COALESCE_EN merges a write into a queued, not yet
// in-flight entry with the same block address.
module l2_mem_write_buffer
    import l2_mem_write_buffer_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int ADDR_W = BLK_ADDR_W,
    parameter int DATA_W = BLK_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     up_read,
    input  logic                     up_write,
    input  logic [ADDR_W-1:0]        up_addr,
    input  logic [DATA_W-1:0]        up_wdata,
    output logic [DATA_W-1:0]        up_rdata,
    output logic                     up_ready,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_ready,
    output logic [$clog2(DEPTH):0]   wb_count
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_state_t         state;
    wb_state_t         state_next;
    logic              miss_pend;
    logic [ADDR_W-1:0] miss_addr;

    logic              wr_req;
    logic              rd_req;
    logic              wr_accept;
    logic              cw_hit;
    logic              fetch_done;
    logic              drain_done;
    logic              drain_busy;
    logic              skip_head;

    logic              hit;
    logic [PTR_W-1:0]  hit_idx;
    logic [DATA_W-1:0] hit_data;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              full;

    logic              mem_read_d;
    logic              mem_write_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;

    // Requests are only looked at while up_ready is low, so a held request
    // that has just been acknowledged is never taken a second time.
    assign wr_req     = up_write && !up_ready;
    assign rd_req     = up_read && !up_write && !up_ready && !miss_pend;
    assign fetch_done = (state == ST_FETCH) && mem_ready;
    assign drain_done = (state == ST_DRAIN) && mem_ready;
    assign drain_busy = (state == ST_DRAIN) || (state_next == ST_DRAIN);
    assign skip_head  = wr_req && drain_busy;

`ifdef WB_COALESCE_EN
    assign cw_hit = wr_req && hit;
`else
    assign cw_hit = 1'b0;
`endif

    // A full buffer still takes a write in the cycle the head is popped.
    assign wr_accept = wr_req && !fetch_done && (!full || drain_done || cw_hit);

    wb_fifo_cam #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (wr_accept && !cw_hit),
        .push_addr  (up_addr),
        .push_data  (up_wdata),
        .pop        (drain_done),
        .ow_en      (wr_accept && cw_hit),
        .ow_idx     (hit_idx),
        .ow_data    (up_wdata),
        .match_addr (up_addr),
        .skip_head  (skip_head),
        .hit        (hit),
        .hit_idx    (hit_idx),
        .hit_data   (hit_data),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .count      (wb_count),
        .full       (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (miss_pend)            state_next = ST_FETCH;
                else if (wb_count != '0)  state_next = ST_DRAIN;
            end
            ST_DRAIN: if (mem_ready) state_next = ST_IDLE;
            ST_FETCH: if (mem_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Memory-side outputs are computed from the next state so they register
    // in the same edge the FSM moves, and drop the edge mem_ready is seen.
    always_comb begin
        mem_read_d  = (state_next == ST_FETCH);
        mem_write_d = (state_next == ST_DRAIN);
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        if (state == ST_IDLE && state_next == ST_FETCH) begin
            mem_addr_d = miss_addr;
        end else if (state == ST_IDLE && state_next == ST_DRAIN) begin
            mem_addr_d  = head_addr;
            mem_wdata_d = head_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_read  <= mem_read_d;
            mem_write <= mem_write_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_ready  <= 1'b0;
            up_rdata  <= '0;
            miss_pend <= 1'b0;
            miss_addr <= '0;
        end else begin
            up_ready <= 1'b0;
            if (wr_accept) begin
                up_ready <= 1'b1;
            end else if (rd_req && hit) begin
                up_ready <= 1'b1;
                up_rdata <= hit_data;
            end else if (fetch_done) begin
                up_ready <= 1'b1;
                up_rdata <= mem_rdata;
            end

            if (rd_req && !hit) begin
                miss_pend <= 1'b1;
                miss_addr <= up_addr;
            end else if (fetch_done) begin
                miss_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_l2_mem_write_buffer.sv
// Directed bench for l2_mem_write_buffer (DEPTH=4); expected drains are held
// in a queue and compared against the memory-side write stream.
module tb_l2_mem_write_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;

    logic                   clk       = 1'b0;
    logic                   rst_n     = 1'b0;
    logic                   up_read   = 1'b0;
    logic                   up_write  = 1'b0;
    logic [ADDR_W-1:0]      up_addr   = '0;
    logic [DATA_W-1:0]      up_wdata  = '0;
    logic [DATA_W-1:0]      up_rdata;
    logic                   up_ready;
    logic                   mem_read;
    logic                   mem_write;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic [DATA_W-1:0]      mem_rdata = '0;
    logic                   mem_ready = 1'b0;
    logic [$clog2(DEPTH):0] wb_count;

    int errors = 0;
    int checks = 0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [DATA_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    l2_mem_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .up_read   (up_read),
        .up_write  (up_write),
        .up_addr   (up_addr),
        .up_wdata  (up_wdata),
        .up_rdata  (up_rdata),
        .up_ready  (up_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .wb_count  (wb_count)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [DATA_W-1:0] pat(input logic [7:0] b);
        return {16{b}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        up_read = 1'b0; up_write = 1'b0; up_addr = '0; up_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        exp_addr_q.delete();
        exp_q.delete();
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                            output int lat);
        up_write = 1'b1; up_addr = addr; up_wdata = data; lat = 0;
        do begin
            step();
            lat++;
        end while (!up_ready && lat < 40);
        checks++;
        if (up_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_ack addr=%h: no up_ready after %0d cycles", addr, lat);
        end
        up_write = 1'b0;
    endtask

    task automatic drain_expect(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n = 0;
        while (mem_write !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (mem_write !== 1'b1) begin
            errors++;
            $display("FAIL drain_start: mem_write never rose, expected addr %h", a);
        end else begin
            checks++;
            if (mem_addr !== a) begin
                errors++;
                $display("FAIL drain_addr: got %h expected %h", mem_addr, a);
            end
            checks++;
            if (mem_wdata !== d) begin
                errors++;
                $display("FAIL drain_data: got %h expected %h", mem_wdata, d);
            end
            checks++;
            if (mem_read !== 1'b0) begin
                errors++;
                $display("FAIL drain_excl: mem_read=%b with mem_write, expected 0", mem_read);
            end
            mem_ready = 1'b1;
            step();
            mem_ready = 1'b0;
            checks++;
            if (mem_write !== 1'b0) begin
                errors++;
                $display("FAIL drain_drop: mem_write=%b after mem_ready, expected 0", mem_write);
            end
        end
    endtask

    task automatic drain_all();
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        while (exp_addr_q.size() > 0) begin
            a = exp_addr_q.pop_front();
            d = exp_q.pop_front();
            drain_expect(a, d);
        end
        checks++;
        if (wb_count !== '0) begin
            errors++;
            $display("FAIL drained_count: wb_count=%0d expected 0", wb_count);
        end
    endtask

    task automatic expect_count(input string name, input int exp);
        checks++;
        if (wb_count !== ($clog2(DEPTH)+1)'(exp)) begin
            errors++;
            $display("FAIL %s: wb_count=%0d expected %0d", name, wb_count, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        checks++;
        if ({up_ready, mem_read, mem_write} !== 3'b000 || up_rdata !== '0 ||
            mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b rd=%b wr=%b rdata=%h addr=%h wdata=%h expected all 0",
                     up_ready, mem_read, mem_write, up_rdata, mem_addr, mem_wdata);
        end
        expect_count("reset_count", 0);
        apply_reset();
    endtask

    task automatic test_single_write();
        int lat;
        apply_reset();
        mem_ready = 1'b1; mem_rdata = pat(8'h55);
        step();
        mem_ready = 1'b0;
        checks++;
        if ({up_ready, mem_read, mem_write} !== 3'b000) begin
            errors++;
            $display("FAIL idle_mem_ready: rdy/rd/wr=%b expected 000", {up_ready, mem_read, mem_write});
        end
        do_write(28'h0000010, pat(8'hAA), lat);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL write_latency: ack after %0d cycles expected 1", lat);
        end
        expect_count("single_count", 1);
        exp_addr_q.push_back(28'h0000010);
        exp_q.push_back(pat(8'hAA));
        drain_all();
    endtask

    task automatic test_full_stall();
        int lat;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            do_write(28'h100 + 28'(i), pat(8'h10 + 8'(i)), lat);
            checks++;
            if (lat != ((i == 0) ? 1 : 2)) begin
                errors++;
                $display("FAIL fill_latency[%0d]: ack after %0d cycles expected %0d",
                         i, lat, (i == 0) ? 1 : 2);
            end
            exp_addr_q.push_back(28'h100 + 28'(i));
            exp_q.push_back(pat(8'h10 + 8'(i)));
        end
        expect_count("full_count", 4);
        up_write = 1'b1; up_addr = 28'h104; up_wdata = pat(8'h14);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (up_ready !== 1'b0) begin
                errors++;
                $display("FAIL full_stall[%0d]: up_ready=%b expected 0", i, up_ready);
            end
        end
        expect_count("stalled_count", 4);
        // the in-flight head is 0x100; complete it by hand
        void'(exp_addr_q.pop_front());
        void'(exp_q.pop_front());
        drain_expect(28'h100, pat(8'h10));
        checks++;
        if (up_ready !== 1'b1) begin
            errors++;
            $display("FAIL fifth_ack: up_ready=%b in cycle after pop, expected 1", up_ready);
        end
        up_write = 1'b0;
        expect_count("push_pop_count", 4);
        exp_addr_q.push_back(28'h104);
        exp_q.push_back(pat(8'h14));
        drain_all();
    endtask

    task automatic read_hit(input string name, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
        step();
        up_read = 1'b1; up_addr = a;
        step();
        up_read = 1'b0;
        checks++;
        if (up_ready !== 1'b1 || up_rdata !== d) begin
            errors++;
            $display("FAIL %s: rdy=%b rdata=%h expected rdy=1 rdata=%h", name, up_ready, up_rdata, d);
        end
        checks++;
        if (mem_read !== 1'b0) begin
            errors++;
            $display("FAIL %s_nomem: mem_read=%b expected 0", name, mem_read);
        end
    endtask

    task automatic test_read_hit();
        int lat;
        apply_reset();
        do_write(28'h10, pat(8'h11), lat);
        do_write(28'h20, pat(8'h22), lat);
        read_hit("hit_tail", 28'h20, pat(8'h22));
        read_hit("hit_inflight", 28'h10, pat(8'h11));
        do_write(28'h20, pat(8'h33), lat);
        read_hit("hit_youngest", 28'h20, pat(8'h33));
        exp_addr_q.push_back(28'h10); exp_q.push_back(pat(8'h11));
`ifndef WB_COALESCE_EN
        exp_addr_q.push_back(28'h20); exp_q.push_back(pat(8'h22));
`endif
        exp_addr_q.push_back(28'h20); exp_q.push_back(pat(8'h33));
        drain_all();
    endtask

    task automatic test_miss_during_drain();
        int lat;
        int n = 0;
        apply_reset();
        do_write(28'h10, pat(8'h11), lat);
        do_write(28'h20, pat(8'h22), lat);
        up_read = 1'b1; up_addr = 28'h30;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (up_ready !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b1) begin
                errors++;
                $display("FAIL miss_wait[%0d]: rdy=%b rd=%b wr=%b expected 0 0 1",
                         i, up_ready, mem_read, mem_write);
            end
        end
        drain_expect(28'h10, pat(8'h11));
        expect_count("miss_count", 1);
        while (mem_read !== 1'b1 && mem_write !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h30) begin
            errors++;
            $display("FAIL fetch_issue: rd=%b wr=%b addr=%h expected rd=1 wr=0 addr 0000030",
                     mem_read, mem_write, mem_addr);
        end
        mem_rdata = pat(8'hC3); mem_ready = 1'b1;
        step();
        mem_ready = 1'b0; mem_rdata = '0;
        checks++;
        if (up_ready !== 1'b1 || up_rdata !== pat(8'hC3)) begin
            errors++;
            $display("FAIL fetch_data: rdy=%b rdata=%h expected rdy=1 rdata=%h",
                     up_ready, up_rdata, pat(8'hC3));
        end
        checks++;
        if (mem_read !== 1'b0) begin
            errors++;
            $display("FAIL fetch_drop: mem_read=%b after mem_ready, expected 0", mem_read);
        end
        up_read = 1'b0;
        exp_addr_q.push_back(28'h20); exp_q.push_back(pat(8'h22));
        drain_all();
    endtask

    task automatic test_coalesce();
        int lat;
        apply_reset();
        do_write(28'h40, pat(8'h44), lat);
        do_write(28'h10, pat(8'h51), lat);
        do_write(28'h10, pat(8'h52), lat);
        exp_addr_q.push_back(28'h40); exp_q.push_back(pat(8'h44));
`ifdef WB_COALESCE_EN
        expect_count("coalesce_count", 2);
        do_write(28'h50, pat(8'h55), lat);
        do_write(28'h60, pat(8'h66), lat);
        expect_count("coalesce_full", 4);
        do_write(28'h10, pat(8'h53), lat);
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL coalesce_full_ack: ack after %0d cycles expected 2", lat);
        end
        expect_count("coalesce_full_after", 4);
        exp_addr_q.push_back(28'h10); exp_q.push_back(pat(8'h53));
        exp_addr_q.push_back(28'h50); exp_q.push_back(pat(8'h55));
        exp_addr_q.push_back(28'h60); exp_q.push_back(pat(8'h66));
`else
        expect_count("dup_count", 3);
        exp_addr_q.push_back(28'h10); exp_q.push_back(pat(8'h51));
        exp_addr_q.push_back(28'h10); exp_q.push_back(pat(8'h52));
`endif
        drain_all();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        apply_reset();
        do_write(28'h70, pat(8'h77), lat);
        do_write(28'h80, pat(8'h88), lat);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b0 || up_ready !== 1'b0 || wb_count !== '0) begin
            errors++;
            $display("FAIL async_reset: wr=%b rdy=%b count=%0d expected 0 0 0",
                     mem_write, up_ready, wb_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) step();
        checks++;
        if (mem_write !== 1'b0 || mem_read !== 1'b0 || wb_count !== '0) begin
            errors++;
            $display("FAIL reset_discard: wr=%b rd=%b count=%0d expected 0 0 0",
                     mem_write, mem_read, wb_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_full_stall();
        test_read_hit();
        test_miss_during_drain();
        test_coalesce();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
